// File: rtl/ldtu_out_fifo_pkg.sv
// Shared LDTU output-FIFO constants: default geometry, idle word and mode-switch state encoding.
package ldtu_out_fifo_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 8;
  localparam int unsigned WORD_W            = 32;
  localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hEAAAAAAA;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage : ldtu_out_fifo_pkg

// File: rtl/ldtu_fifo_mem.sv
// DEPTH x 32 storage array: synchronous write, combinational read at the read pointer.
module ldtu_fifo_mem
  import ldtu_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents are left unreset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ldtu_fifo_mem

// File: rtl/ldtu_out_fifo.sv
// LDTU output FIFO: selects normal/fallback word stream, buffers words for the serializer,
// and flushes its contents for one cycle whenever the stream mode changes.
module ldtu_out_fifo
  import ldtu_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     rst_b,
  input  logic                     fallback,
  input  logic [31:0]              DATA_32,
  input  logic                     Load,
  input  logic [31:0]              DATA_32_FB,
  input  logic                     Load_FB,
  input  logic                     read_req,
  output logic [31:0]              DATA_out,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  state_e            state_q, state_d;
  logic              fallback_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, full_q, ovf_q, ovf_d;
  logic [WORD_W-1:0] data_q, data_d;

  logic              run, wr_stb, wr_en, rd_en, drop;
  logic [WORD_W-1:0] wr_data, rd_data;

  ldtu_fifo_mem #(.DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (CLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Next-state logic for pointers, occupancy, output word and mode FSM.
  always_comb begin
    run      = (state_q == ST_RUN);
    wr_stb   = fallback_q ? Load_FB : Load;
    wr_data  = fallback_q ? DATA_32_FB : DATA_32;
    rd_en    = run && read_req && (level_q != '0);
    wr_en    = run && wr_stb && (!full_q || rd_en);
    drop     = run && wr_stb && full_q && !read_req;

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    ovf_d    = ovf_q | drop;

    if (read_req) data_d = rd_en ? rd_data : IDLE_WORD;

    if (run) begin
      if (fallback != fallback_q) state_d = ST_FLUSH;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !rd_en)      level_d = level_q + LW'(1);
      else if (rd_en && !wr_en) level_d = level_q - LW'(1);
    end else begin
      state_d  = ST_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      state_q    <= ST_RUN;
      fallback_q <= fallback;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= IDLE_WORD;
    end else begin
      state_q    <= state_d;
      fallback_q <= fallback;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == LW'(DEPTH));
      ovf_q      <= ovf_d;
      data_q     <= data_d;
    end
  end

  assign DATA_out   = data_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule : ldtu_out_fifo

// File: tb/tb_ldtu_out_fifo.sv
// Self-checking bench for ldtu_out_fifo: directed scenarios plus random traffic against a queue model.
module tb_ldtu_out_fifo;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] IDLE  = 32'hEAAAAAAA;

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic        fallback = 1'b0;
  logic [31:0] DATA_32 = '0;
  logic        Load = 1'b0;
  logic [31:0] DATA_32_FB = '0;
  logic        Load_FB = 1'b0;
  logic        read_req = 1'b0;
  logic [31:0] DATA_out;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  level;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  // Reference model: a word queue plus the few flags the block exposes.
  logic [31:0] m_q [$];
  logic [31:0] m_dout;
  logic        m_ovf;
  logic        m_fbq;
  logic        m_flush;

  ldtu_out_fifo #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
    .CLK        (CLK),
    .rst_b      (rst_b),
    .fallback   (fallback),
    .DATA_32    (DATA_32),
    .Load       (Load),
    .DATA_32_FB (DATA_32_FB),
    .Load_FB    (Load_FB),
    .read_req   (read_req),
    .DATA_out   (DATA_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        stb;
    logic [31:0] wd;
    if (!rst_b) begin
      m_q.delete();
      m_dout  = IDLE;
      m_ovf   = 1'b0;
      m_flush = 1'b0;
    end else if (m_flush) begin
      m_q.delete();
      if (read_req) m_dout = IDLE;
      m_flush = 1'b0;
    end else begin
      stb = m_fbq ? Load_FB : Load;
      wd  = m_fbq ? DATA_32_FB : DATA_32;
      if (read_req) m_dout = (m_q.size() > 0) ? m_q.pop_front() : IDLE;
      if (stb) begin
        if (m_q.size() < DEPTH) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end
      m_flush = (fallback != m_fbq);
    end
    m_fbq = fallback;
  endtask

  // One clock: advance the model at the edge, check outputs 1ns later, drop one-shot strobes.
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    chk("DATA_out", DATA_out, m_dout);
    chk("level", 32'(level), 32'(m_q.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    Load = 1'b0;
    Load_FB = 1'b0;
    read_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    cycle();
    rst_b = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_dout", DATA_out, IDLE);
    chk("rst_empty", 32'(fifo_empty), 32'd1);

    // Reads of an empty FIFO return the idle word
    for (int i = 0; i < 12; i++) begin
      read_req = (i % 4 == 3);
      cycle();
    end
    chk("idle_read", DATA_out, IDLE);

    // Two words in, two words out
    DATA_32 = 32'h11111111; Load = 1'b1; cycle();
    DATA_32 = 32'h22222222; Load = 1'b1; cycle();
    chk("lvl2", 32'(level), 32'd2);
    read_req = 1'b1; cycle();
    chk("rd1", DATA_out, 32'h11111111);
    read_req = 1'b1; cycle();
    chk("rd2", DATA_out, 32'h22222222);
    chk("lvl0", 32'(level), 32'd0);

    // Fill past capacity, then drain in order
    for (int i = 1; i <= 9; i++) begin
      DATA_32 = 32'(i); Load = 1'b1; cycle();
      if (i == 8) chk("full_at_8", 32'(fifo_full), 32'd1);
    end
    chk("ovf_at_9", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      read_req = 1'b1; cycle();
      chk("drain", DATA_out, 32'(i));
    end

    // Write into empty FIFO with simultaneous read: no fall-through
    DATA_32 = 32'hA5A5A5A5; Load = 1'b1; read_req = 1'b1; cycle();
    chk("no_fallthru", DATA_out, IDLE);
    read_req = 1'b1; cycle();
    chk("after_fallthru", DATA_out, 32'hA5A5A5A5);

    // Full FIFO with paired write/read, across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      DATA_32 = 32'h100 + 32'(i); Load = 1'b1; cycle();
    end
    for (int i = 0; i < 21; i++) begin
      DATA_32 = 32'h200 + 32'(i); Load = 1'b1; read_req = 1'b1; cycle();
      chk("pair_lvl", 32'(level), 32'd8);
    end
    chk("pair_ovf", 32'(overflow), 32'd0);
    chk("pair_last", DATA_out, 32'h20C);

    // Mode switch flushes the old stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      DATA_32 = 32'hC0 + 32'(i); Load = 1'b1; cycle();
    end
    fallback = 1'b1; cycle();
    cycle();
    read_req = 1'b1; cycle();
    chk("flush_idle", DATA_out, IDLE);
    DATA_32 = 32'h12345678; Load = 1'b1; cycle();
    DATA_32_FB = 32'h0DEADBEE; Load_FB = 1'b1; cycle();
    read_req = 1'b1; cycle();
    chk("fb_word", DATA_out, 32'h0DEADBEE);
    read_req = 1'b1; cycle();
    chk("fb_ignores_normal", DATA_out, IDLE);

    // Mid-operation reset discards stored words
    for (int i = 0; i < 4; i++) begin
      DATA_32_FB = 32'h77 + 32'(i); Load_FB = 1'b1; cycle();
    end
    do_reset();
    read_req = 1'b1; cycle();
    chk("post_rst_read", DATA_out, IDLE);

    // Random traffic with occasional mode switches and resets
    for (int i = 0; i < 600; i++) begin
      rst_b      = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 39) == 0) fallback = ~fallback;
      Load       = ($urandom_range(0, 1) == 1);
      DATA_32    = $urandom;
      Load_FB    = ($urandom_range(0, 1) == 1);
      DATA_32_FB = $urandom;
      read_req   = ($urandom_range(0, 4) < 2);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ldtu_out_fifo
